// File: rtl/mem_responder_if.sv
// CPU-side bus and preload port of the memory responder.
// The shared tri-state data bus stays a plain inout port on the responder.
interface mem_responder_if #(
    parameter int ADR_W  = 6,
    parameter int DATA_W = 8
);
    logic [ADR_W-1:0]  adr_bus;
    logic              rd_mem;
    logic              wr_mem;
    logic              mem_rdy;
    logic              ld_en;
    logic [ADR_W-1:0]  ld_adr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;

    modport slave (
        input  adr_bus, rd_mem, wr_mem, ld_en, ld_adr, ld_data,
        output mem_rdy, ld_ack
    );

    modport master (
        output adr_bus, rd_mem, wr_mem, ld_en, ld_adr, ld_data,
        input  mem_rdy, ld_ack
    );
endinterface

// File: rtl/mem_responder.sv
// 64x8 memory responder for the CPU external bus: programmable wait states,
// write-protected upper region, preload port and sticky bus-error flags.
module mem_responder #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PROT_BASE   = 48,
    parameter int          ADR_W       = 6,
    parameter int          DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              wr_err,
    output logic              bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

    localparam logic [2:0]     WS       = 3'(WAIT_STATES);
    localparam logic [ADR_W:0] PROT_LIM = (ADR_W+1)'(PROT_BASE);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic              wr_err_q, wr_err_d;
    logic              bus_err_q, bus_err_d;
    logic              ld_ack_q, ld_ack_d;

    logic [DATA_W-1:0] mem [0:(1<<ADR_W)-1];

    logic              one, both, rdy, data_oe, we_cpu, prot, ld_go;
    logic [ADR_W-1:0]  addr;

    assign one  = bus.rd_mem ^ bus.wr_mem;
    assign both = bus.rd_mem & bus.wr_mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            wr_err_q  <= 1'b0;
            bus_err_q <= 1'b0;
            ld_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            wr_err_q  <= wr_err_d;
            bus_err_q <= bus_err_d;
            ld_ack_q  <= ld_ack_d;
        end
    end

    // Counter tracks the cycle index of the access; ACCESS is entered as it reaches WS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        if (both) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (one) begin
                    adr_d   = bus.adr_bus;
                    cnt_d   = 3'd1;
                    state_d = (WAIT_STATES <= 1) ? S_ACCESS : S_WAIT;
                end
                S_WAIT: if (!one) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d == WS) state_d = S_ACCESS;
                end
                S_ACCESS: if (!bus.rd_mem && !bus.wr_mem) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Zero-wait mode answers combinationally off the live address.
    always_comb begin
        rdy       = (WAIT_STATES == 0) ? one : ((state_q == S_ACCESS) && !both);
        addr      = (WAIT_STATES == 0) ? bus.adr_bus : adr_q;
        data_oe   = bus.rd_mem && !bus.wr_mem && rdy;
        we_cpu    = bus.wr_mem && !bus.rd_mem && rdy;
        prot      = {1'b0, addr} >= PROT_LIM;
        ld_go     = bus.ld_en && (state_q == S_IDLE) && !bus.rd_mem && !bus.wr_mem;
        wr_err_d  = wr_err_q | (we_cpu & prot);
        bus_err_d = bus_err_q | both;
        ld_ack_d  = ld_go;
    end

    // RAM has no reset; CPU write and preload are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (we_cpu && !prot) mem[addr] <= data_bus;
        else if (ld_go)      mem[bus.ld_adr] <= bus.ld_data;
    end

    assign data_bus    = data_oe ? mem[addr] : 'z;
    assign bus.mem_rdy = rdy;
    assign bus.ld_ack  = ld_ack_q;
    assign wr_err      = wr_err_q;
    assign bus_err     = bus_err_q;
endmodule
